l1_conv_out_reader: RTL

//  Read-side controller for the L1 convolution local output RAM. Once the write

---
 rtl/l1_conv_out_reader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/l1_conv_out_reader.sv
`default_nettype none
// ============================================================================
// Module   : l1_conv_out_reader
// Brief    : Streams one L1 convolution feature map out of the local output
//            RAM through a 2-entry skid FIFO with a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module l1_conv_out_reader #(
    parameter int DEPTH  = 25,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ConvReady_i,
    output logic [ADDR_W-1:0] RamRdAddr_o,
    output logic              RamRe_o,
    input  logic [DATA_W-1:0] RamRdData_i,
    output logic              DataValid_o,
    output logic [DATA_W-1:0] Data_o,
    output logic              Last_o,
    input  logic              DataReady_i,
    output logic              Busy_o,
    output logic              Done_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_READ     = 2'd1,
        S_DRAIN    = 2'd2,
        S_WAIT_REL = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         idx_q, idx_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic                      vld_q, vld_d;
    logic                      vld_last_q, vld_last_d;
    logic                      done_q, done_d;
    logic [1:0][DATA_W-1:0]    mem_q, mem_d;
    logic [1:0]                last_q, last_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic                      wr_ptr_q, wr_ptr_d;
    logic [1:0]                cnt_q, cnt_d;

    logic                      w_pop;
    logic                      w_push;
    logic                      w_issue;
    logic [2:0]                w_occ;

    always_comb begin
        w_pop   = (cnt_q != 2'd0) && DataReady_i;
        w_push  = vld_q;
        // Entries committed after this edge: buffered plus the word now on
        // the RAM bus, minus what leaves; a new read claims the next slot.
        w_occ   = {1'b0, cnt_q} + {2'b00, vld_q} - {2'b00, w_pop};
        w_issue = (state_q == S_READ) && (w_occ < 3'd2);

        state_d    = state_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        vld_d      = w_issue;
        vld_last_d = w_issue && (idx_q == C_LAST_ADDR);
        done_d     = 1'b0;
        mem_d      = mem_q;
        last_d     = last_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q + {1'b0, w_push} - {1'b0, w_pop};

        if (w_issue) begin
            addr_d = idx_q;
            if (idx_q != C_LAST_ADDR) begin
                idx_d = idx_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (ConvReady_i) begin
                    state_d = S_READ;
                    idx_d   = '0;
                end
            end
            S_READ: begin
                if (w_issue && (idx_q == C_LAST_ADDR)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && last_q[rd_ptr_q]) begin
                    state_d = S_WAIT_REL;
                    done_d  = 1'b1;
                end
            end
            S_WAIT_REL: begin
                if (!ConvReady_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_push) begin
            mem_d[wr_ptr_q]  = RamRdData_i;
            last_d[wr_ptr_q] = vld_last_q;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (w_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            addr_q     <= '0;
            vld_q      <= 1'b0;
            vld_last_q <= 1'b0;
            done_q     <= 1'b0;
            mem_q      <= '0;
            last_q     <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            vld_q      <= vld_d;
            vld_last_q <= vld_last_d;
            done_q     <= done_d;
            mem_q      <= mem_d;
            last_q     <= last_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign RamRe_o     = w_issue;
    assign RamRdAddr_o = w_issue ? idx_q : addr_q;
    assign DataValid_o = (cnt_q != 2'd0);
    assign Data_o      = DataValid_o ? mem_q[rd_ptr_q] : '0;
    assign Last_o      = DataValid_o && last_q[rd_ptr_q];
    assign Busy_o      = (state_q == S_READ) || (state_q == S_DRAIN);
    assign Done_o      = done_q;

endmodule
`default_nettype wire
